seq_shift_add_multiplier: RTL and testbench

SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

---
 rtl/seq_shift_add_multiplier.sv | 126 ++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Purpose: sequential shift-and-add multiplier. One multiplier bit is
// processed per clock, LSB first, so a multiply takes WIDTH RUN cycles plus
// one FINISH cycle. Supports unsigned and two's-complement operands.
//
// Ports:
//   CLK          in   rising-edge clock
//   RST          in   asynchronous active-high reset
//   START        in   begin a multiply (accepted only in IDLE)
//   SIGNED_MODE  in   1 = two's complement operands, 0 = unsigned
//   A            in   multiplicand  [WIDTH-1:0]
//   B            in   multiplier    [WIDTH-1:0]
//   BUSY         out  high in RUN and FINISH
//   DONE         out  one-cycle pulse while PRODUCT holds a new result
//   PRODUCT      out  registered result [2*WIDTH-1:0]
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SIGNED_MODE,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   PRODUCT
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;        // multiplicand, already extended to PW bits
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [PW-1:0]    pp;              // partial product for the current bit

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    pp      = '0;

    case (state_q)
      IDLE: begin
        if (START) begin
          // Extend once at capture so the RUN datapath is mode-agnostic
          // except for the final subtract.
          a_d     = SIGNED_MODE ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
          b_d     = B;
          sgn_d   = SIGNED_MODE;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        pp = b_q[cnt_q] ? (a_q << cnt_q) : '0;
        // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement.
        if (sgn_q && (cnt_q == LAST_BIT)) begin
          acc_d = acc_q - pp;
        end else begin
          acc_d = acc_q + pp;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // PRODUCT is loaded only here so it never exposes partial sums.
          prod_d  = acc_d;
          state_d = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign BUSY    = (state_q != IDLE);
  assign DONE    = (state_q == FINISH);
  assign PRODUCT = prod_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//
// Scoreboard bench for seq_shift_add_multiplier. Two instances: WIDTH=8 for
// directed vectors, WIDTH=4 for every operand pair in both modes. Drivers
// push {expected product, expected DONE edge} into a queue per instance; a
// monitor per instance pops on DONE and also checks PRODUCT holds between
// results.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

  typedef struct {
    logic [15:0] prod;
    int unsigned edge_n;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t q8[$];
  exp_t q4[$];

  // WIDTH = 8 instance
  logic        rst8, start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst8), .START(start8), .SIGNED_MODE(sgn8),
    .A(a8), .B(b8), .BUSY(busy8), .DONE(done8), .PRODUCT(prod8)
  );

  // WIDTH = 4 instance
  logic        rst4, start4, sgn4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst4), .START(start4), .SIGNED_MODE(sgn4),
    .A(a4), .B(b4), .BUSY(busy4), .DONE(done4), .PRODUCT(prod4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  logic [15:0] last8 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst8) begin
      last8 = '0;
    end else if (done8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL w8_unexpected_done: got DONE=1 expected no DONE (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk({"w8_product_", e.tag}, {16'd0, prod8}, {16'd0, e.prod});
        chk({"w8_done_edge_", e.tag}, cyc, e.edge_n);
        $display("w8 %s: product=0x%04h expected=0x%04h at cycle %0d", e.tag, prod8, e.prod, cyc);
        last8 = e.prod;
      end
    end else begin
      chk("w8_product_hold", {16'd0, prod8}, {16'd0, last8});
    end
  end

  logic [7:0] last4 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst4) begin
      last4 = '0;
    end else if (done4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL w4_unexpected_done: got DONE=1 expected no DONE (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        chk({"w4_product_", e.tag}, {24'd0, prod4}, {24'd0, e.prod[7:0]});
        chk({"w4_done_edge_", e.tag}, cyc, e.edge_n);
        $display("w4 %s: product=0x%02h expected=0x%02h", e.tag, prod4, e.prod[7:0]);
        last4 = e.prod[7:0];
      end
    end else begin
      chk("w4_product_hold", {24'd0, prod4}, {24'd0, last4});
    end
  end

  // ---------------- drivers ----------------
  // Called at posedge+2; START is sampled at the next edge (edge 0 of the op).
  // Returns at posedge+2 after edge WIDTH+1, i.e. minimum issue interval.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] expv, input string tag);
    start8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
    q8.push_back('{expv, cyc + 1 + 8, tag});
    @(posedge clk); #2;
    // Scramble operands right after capture; the result must not change.
    start8 = 1'b0; a8 = ~a; b8 = ~b; sgn8 = ~s;
    chk({"w8_busy_e0_", tag}, {31'd0, busy8}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #2;
      chk({"w8_busy_run_", tag}, {31'd0, busy8}, 32'd1);
    end
    @(posedge clk); #2;
    chk({"w8_busy_idle_", tag}, {31'd0, busy8}, 32'd0);
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [7:0] expv);
    start4 = 1'b1; a4 = a; b4 = b; sgn4 = s;
    q4.push_back('{{8'd0, expv}, cyc + 1 + 4, $sformatf("s%0d_%0h_%0h", s, a, b)});
    @(posedge clk); #2;
    start4 = 1'b0; a4 = ~a; b4 = ~b; sgn4 = ~s;
    repeat (5) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic run8;
    // Unsigned max * max
    issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
    // Signed corner cases
    issue8(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
    issue8(8'hFF, 8'h7F, 1'b1, 16'hFF81, "s_ff_7f");
    issue8(8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_7f_7f");
    issue8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_ff_ff");
    issue8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_80_7f");
    issue8(8'h80, 8'h02, 1'b0, 16'h0100, "u_80_02");
    // Zero multiplicand still takes the full latency
    issue8(8'h00, 8'hAA, 1'b0, 16'h0000, "u_00_aa");

    // START held high for the whole operation with operands toggling.
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sgn8 = 1'b0;
    q8.push_back('{16'h03A8, cyc + 1 + 8, "hold_first"});
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk); #2;
      if (k < 9) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      end else begin
        chk("w8_busy_gap_edge9", {31'd0, busy8}, 32'd0);
        a8 = 8'h0A; b8 = 8'h0B; sgn8 = 1'b0;
        q8.push_back('{16'h006E, cyc + 1 + 8, "hold_second"});
      end
    end
    @(posedge clk); #2;
    start8 = 1'b0;
    chk("w8_busy_reaccept_edge10", {31'd0, busy8}, 32'd1);
    repeat (9) begin
      @(posedge clk); #2;
    end
    chk("w8_busy_after_hold", {31'd0, busy8}, 32'd0);

    // Reset in RUN cycle 4 aborts with no DONE.
    start8 = 1'b1; a8 = 8'h21; b8 = 8'h43; sgn8 = 1'b0;
    q8.push_back('{16'h08A3, cyc + 1 + 8, "aborted"});
    @(posedge clk); #2;
    start8 = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
    end
    rst8 = 1'b1;
    q8.delete();
    #1;
    chk("w8_rst_busy", {31'd0, busy8}, 32'd0);
    chk("w8_rst_done", {31'd0, done8}, 32'd0);
    chk("w8_rst_product", {16'd0, prod8}, 32'd0);
    @(posedge clk); #2;
    rst8 = 1'b0;
    issue8(8'h03, 8'h05, 1'b0, 16'h000F, "u_03_05_after_rst");
  endtask

  task automatic run4;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          int sa, sb;
          logic [7:0] e;
          if (s == 1) begin
            sa = (a >= 8) ? a - 16 : a;
            sb = (b >= 8) ? b - 16 : b;
          end else begin
            sa = a;
            sb = b;
          end
          e = 8'(sa * sb);
          issue4(4'(a), 4'(b), 1'(s), e);
        end
      end
    end
  endtask

  initial begin
    rst8 = 1'b1; start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b1; start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("w8_reset_busy", {31'd0, busy8}, 32'd0);
    chk("w8_reset_done", {31'd0, done8}, 32'd0);
    chk("w8_reset_product", {16'd0, prod8}, 32'd0);
    chk("w4_reset_busy", {31'd0, busy4}, 32'd0);
    chk("w4_reset_product", {24'd0, prod4}, 32'd0);
    rst8 = 1'b0;
    rst4 = 1'b0;
    // First op is issued immediately, so START lands on the first edge after reset.
    fork
      run8();
      run4();
    join
    repeat (20) @(posedge clk);
    #2;
    if (q8.size() != 0 || q4.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d/%0d results outstanding expected 0/0", q8.size(), q4.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
